// File: rtl/cmd_router.sv
// cmd_router: accepts single-cycle commands and routes them by target device.
//   Local commands (cmd_dev == DEV_ID) run a three-step issue/capture sequence
//   toward N_LOC local channels and return readback on cmd_q.
//   Remote commands (any other device) are queued in a RF_DEPTH-entry FIFO
//   and presented on cmdr_* with a valid/ready handshake.
//   Broadcast (cmd_dev == 8'hFF) takes both paths.
//   Commands offered while cmd_rdy is low are dropped and counted in drop_cnt,
//   which saturates at 255.
//
// Ports
//   clk_sys, rst_n                    clock, async active-low reset
//   cmd_dev/mod/addr/data, cmd_vld    command in
//   cmd_rdy                           command accepted this cycle if cmd_vld
//   cmd_q, cmd_err, drop_cnt          local readback, bad-module pulse, drops
//   cmdr_dev/mod/addr/data, cmdr_vld  remote FIFO head
//   cmdr_rdy                          downstream accepts remote head
//   cmdl_mod/addr/data, cmdl_vld      latched local command, one-hot strobe
//   cmdl_q                            per-channel readback, channel k at [k*DW +: DW]
//
// Local FSM
//   state    | meaning
//   ST_IDLE  | ready for a new local command
//   ST_ISSUE | cmdl_vld strobe (or cmd_err for a bad module) is driven
//   ST_CAPT  | channel readback is registered into cmd_q
module cmd_router #(
  parameter logic [7:0] DEV_ID   = 8'h01,
  parameter int         DW       = 8,
  parameter int         N_LOC    = 4,
  parameter int         RF_DEPTH = 4
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic [7:0]          cmd_dev,
  input  logic [7:0]          cmd_mod,
  input  logic [7:0]          cmd_addr,
  input  logic [DW-1:0]       cmd_data,
  input  logic                cmd_vld,
  output logic                cmd_rdy,
  output logic [DW-1:0]       cmd_q,
  output logic                cmd_err,
  output logic [7:0]          drop_cnt,
  output logic [7:0]          cmdr_dev,
  output logic [7:0]          cmdr_mod,
  output logic [7:0]          cmdr_addr,
  output logic [DW-1:0]       cmdr_data,
  output logic                cmdr_vld,
  input  logic                cmdr_rdy,
  output logic [7:0]          cmdl_mod,
  output logic [7:0]          cmdl_addr,
  output logic [DW-1:0]       cmdl_data,
  output logic [N_LOC-1:0]    cmdl_vld,
  input  logic [N_LOC*DW-1:0] cmdl_q
);

  localparam int AW = $clog2(RF_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0]    dev;
    logic [7:0]    mod;
    logic [7:0]    addr;
    logic [DW-1:0] data;
  } rcmd_t;

  state_e        state_q, state_d;
  logic [7:0]    mod_q, addr_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] rdbk_q;
  logic [7:0]    drop_q;

  rcmd_t         fifo_q [RF_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic          full, accept, is_local, is_remote, push, pop, mod_ok;
  logic [N_LOC-1:0] vld_dec;
  logic [DW-1:0] rdbk_sel;

  assign full      = (count_q == (AW+1)'(RF_DEPTH));
  // rst_n gates ready directly so it reads low during reset and high in the
  // very first cycle after release, without waiting for a clock edge.
  assign cmd_rdy   = rst_n & (state_q == ST_IDLE) & ~full;
  assign accept    = cmd_vld & cmd_rdy;
  assign is_local  = (cmd_dev == DEV_ID) || (cmd_dev == 8'hFF);
  assign is_remote = (cmd_dev != DEV_ID) || (cmd_dev == 8'hFF);
  assign push      = accept & is_remote;
  assign cmdr_vld  = (count_q != '0);
  assign pop       = cmdr_vld & cmdr_rdy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && is_local) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Module decode; an out-of-range module leaves the strobe empty and the
  // readback at all ones.
  always_comb begin
    vld_dec  = '0;
    mod_ok   = 1'b0;
    rdbk_sel = '1;
    for (int k = 0; k < N_LOC; k++) begin
      if (mod_q == 8'(k)) begin
        mod_ok     = 1'b1;
        vld_dec[k] = 1'b1;
        rdbk_sel   = cmdl_q[k*DW +: DW];
      end
    end
  end

  assign cmdl_vld  = (state_q == ST_ISSUE) ? vld_dec : '0;
  assign cmd_err   = (state_q == ST_ISSUE) && !mod_ok;
  assign cmdl_mod  = mod_q;
  assign cmdl_addr = addr_q;
  assign cmdl_data = data_q;
  assign cmd_q     = rdbk_q;
  assign drop_cnt  = drop_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mod_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdbk_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept && is_local) begin
        mod_q  <= cmd_mod;
        addr_q <= cmd_addr;
        data_q <= cmd_data;
      end
      if (state_q == ST_CAPT) rdbk_q <= rdbk_sel;
      if (cmd_vld && !cmd_rdy && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  // Remote FIFO: entry is written on the accept edge so it is at the head
  // (cmdr_vld high) the cycle after accept. Ready already excludes full.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {cmd_dev, cmd_mod, cmd_addr, cmd_data};
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign cmdr_dev  = fifo_q[rd_ptr_q].dev;
  assign cmdr_mod  = fifo_q[rd_ptr_q].mod;
  assign cmdr_addr = fifo_q[rd_ptr_q].addr;
  assign cmdr_data = fifo_q[rd_ptr_q].data;

endmodule

// File: tb/tb_cmd_router.sv
// Testbench for cmd_router: directed scenarios plus a randomized run checked
// against a transaction-level reference model (phase counter + queue).
module tb_cmd_router;
  localparam logic [7:0] DEV_ID = 8'h01;
  localparam int DW = 8;
  localparam int N_LOC = 4;
  localparam int RF_DEPTH = 4;

  logic                clk_sys = 1'b0;
  logic                rst_n = 1'b0;
  logic [7:0]          cmd_dev, cmd_mod, cmd_addr;
  logic [DW-1:0]       cmd_data;
  logic                cmd_vld;
  logic                cmd_rdy;
  logic [DW-1:0]       cmd_q;
  logic                cmd_err;
  logic [7:0]          drop_cnt;
  logic [7:0]          cmdr_dev, cmdr_mod, cmdr_addr;
  logic [DW-1:0]       cmdr_data;
  logic                cmdr_vld;
  logic                cmdr_rdy;
  logic [7:0]          cmdl_mod, cmdl_addr;
  logic [DW-1:0]       cmdl_data;
  logic [N_LOC-1:0]    cmdl_vld;
  logic [N_LOC*DW-1:0] cmdl_q;

  int n_chk = 0;
  int n_fail = 0;

  cmd_router #(.DEV_ID(DEV_ID), .DW(DW), .N_LOC(N_LOC), .RF_DEPTH(RF_DEPTH)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .cmd_dev(cmd_dev), .cmd_mod(cmd_mod), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_q(cmd_q), .cmd_err(cmd_err),
    .drop_cnt(drop_cnt),
    .cmdr_dev(cmdr_dev), .cmdr_mod(cmdr_mod), .cmdr_addr(cmdr_addr),
    .cmdr_data(cmdr_data), .cmdr_vld(cmdr_vld), .cmdr_rdy(cmdr_rdy),
    .cmdl_mod(cmdl_mod), .cmdl_addr(cmdl_addr), .cmdl_data(cmdl_data),
    .cmdl_vld(cmdl_vld), .cmdl_q(cmdl_q)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_vld = 1'b0; cmd_dev = '0; cmd_mod = '0; cmd_addr = '0; cmd_data = '0;
    cmdr_rdy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic send(input logic [7:0] dev, input logic [7:0] md,
                      input logic [7:0] ad, input logic [DW-1:0] dt);
    cmd_dev = dev; cmd_mod = md; cmd_addr = ad; cmd_data = dt; cmd_vld = 1'b1;
    tick();
    cmd_vld = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    cmdl_q = 32'hDEADBEEF;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({cmd_rdy, cmdl_vld, cmdr_vld, cmd_err, drop_cnt, cmd_q} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b lvld=%b rvld=%b err=%b drop=%0d q=%h, want all 0",
               cmd_rdy, cmdl_vld, cmdr_vld, cmd_err, drop_cnt, cmd_q);
    end
    n_chk++;
    if ({cmdl_mod, cmdl_addr, cmdl_data, cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: got l=%h/%h/%h r=%h/%h/%h/%h, want 0",
               cmdl_mod, cmdl_addr, cmdl_data, cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rdy: got %b want 1", cmd_rdy);
    end
  endtask

  task automatic test_local_write();
    do_reset();
    cmdl_q = {8'h44, 8'h3C, 8'h22, 8'h11};
    send(8'h01, 8'd2, 8'h10, 8'hA5);
    n_chk++;
    if (cmdl_vld !== 4'b0100 || cmd_err !== 1'b0 || cmdr_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL local_issue: got lvld=%b err=%b rvld=%b want 0100/0/0", cmdl_vld, cmd_err, cmdr_vld);
    end
    n_chk++;
    if ({cmdl_mod, cmdl_addr, cmdl_data} !== {8'd2, 8'h10, 8'hA5}) begin
      n_fail++;
      $display("FAIL local_fields: got %h/%h/%h want 02/10/a5", cmdl_mod, cmdl_addr, cmdl_data);
    end
    n_chk++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL local_rdy_issue: got %b want 0", cmd_rdy);
    end
    tick();
    n_chk++;
    if (cmd_rdy !== 1'b0 || cmdl_vld !== 4'b0000) begin
      n_fail++;
      $display("FAIL local_capt: got rdy=%b lvld=%b want 0/0000", cmd_rdy, cmdl_vld);
    end
    tick();
    n_chk++;
    if (cmd_q !== 8'h3C || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL local_readback: got q=%h rdy=%b want 3c/1", cmd_q, cmd_rdy);
    end
    n_chk++;
    if ({cmdl_mod, cmdl_addr, cmdl_data} !== {8'd2, 8'h10, 8'hA5}) begin
      n_fail++;
      $display("FAIL local_hold: got %h/%h/%h want 02/10/a5", cmdl_mod, cmdl_addr, cmdl_data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    cmdr_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      n_chk++;
      if (cmd_rdy !== (i <= 4)) begin
        n_fail++;
        $display("FAIL bp_rdy_%0d: got %b want %b", i, cmd_rdy, (i <= 4));
      end
      send(8'h02, 8'(i), 8'(8'h20 + i), 8'(i));
    end
    n_chk++;
    if (drop_cnt !== 8'd1 || cmdr_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drop: got drop=%0d rvld=%b want 1/1", drop_cnt, cmdr_vld);
    end
    cmdr_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_chk++;
      if (cmdr_vld !== 1'b1 || cmdr_data !== 8'(i) || cmdr_dev !== 8'h02) begin
        n_fail++;
        $display("FAIL bp_order_%0d: got vld=%b dev=%h data=%h want 1/02/%h",
                 i, cmdr_vld, cmdr_dev, cmdr_data, 8'(i));
      end
      tick();
    end
    n_chk++;
    if (cmdr_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: got %b want 0", cmdr_vld);
    end
  endtask

  task automatic test_broadcast();
    do_reset();
    cmdl_q = {8'h04, 8'h03, 8'h02, 8'h77};
    send(8'hFF, 8'd0, 8'h33, 8'h5A);
    n_chk++;
    if (cmdl_vld !== 4'b0001) begin
      n_fail++;
      $display("FAIL bcast_local: got lvld=%b want 0001", cmdl_vld);
    end
    n_chk++;
    if (cmdr_vld !== 1'b1 || {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} !== {8'hFF, 8'h00, 8'h33, 8'h5A}) begin
      n_fail++;
      $display("FAIL bcast_remote: got vld=%b %h/%h/%h/%h want 1 ff/00/33/5a",
               cmdr_vld, cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data);
    end
  endtask

  task automatic test_bad_module();
    do_reset();
    cmdl_q = 32'h12345678;
    send(8'h01, 8'd7, 8'h40, 8'h99);
    n_chk++;
    if (cmd_err !== 1'b1 || cmdl_vld !== 4'b0000) begin
      n_fail++;
      $display("FAIL bad_issue: got err=%b lvld=%b want 1/0000", cmd_err, cmdl_vld);
    end
    tick();
    n_chk++;
    if (cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_err_width: got %b want 0", cmd_err);
    end
    tick();
    n_chk++;
    if (cmd_q !== 8'hFF) begin
      n_fail++;
      $display("FAIL bad_q: got %h want ff", cmd_q);
    end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    cmdr_rdy = 1'b0;
    for (int i = 0; i < RF_DEPTH; i++) send(8'h05, 8'd0, 8'd0, 8'(i));
    cmd_dev = 8'h05; cmd_vld = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 253) begin
        n_chk++;
        if (drop_cnt !== 8'd254) begin
          n_fail++;
          $display("FAIL drop_254: got %0d want 254", drop_cnt);
        end
      end
    end
    cmd_vld = 1'b0;
    n_chk++;
    if (drop_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL drop_sat: got %0d want 255", drop_cnt);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    cmdr_rdy = 1'b0;
    cmdl_q = 32'hAABBCCDD;
    for (int i = 0; i < 3; i++) send(8'h09, 8'd1, 8'd2, 8'(8'h30 + i));
    send(8'h01, 8'd1, 8'h55, 8'h66);
    n_chk++;
    if (cmdl_vld !== 4'b0010 || cmdr_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_pre: got lvld=%b rvld=%b want 0010/1", cmdl_vld, cmdr_vld);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({cmd_rdy, cmdl_vld, cmdr_vld, cmd_err, drop_cnt, cmd_q, cmdl_mod, cmdl_addr, cmdl_data,
         cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: got rdy=%b lvld=%b rvld=%b err=%b q=%h l=%h/%h/%h r=%h/%h",
               cmd_rdy, cmdl_vld, cmdr_vld, cmd_err, cmd_q, cmdl_mod, cmdl_addr, cmdl_data,
               cmdr_dev, cmdr_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (cmdr_vld !== 1'b0 || cmdl_vld !== 4'b0000 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_after: got rvld=%b lvld=%b rdy=%b want 0/0000/1", cmdr_vld, cmdl_vld, cmd_rdy);
    end
  endtask

  // Reference model: local path as a phase number (0 idle, 1 issue, 2 capture),
  // remote path as a queue of pending commands.
  typedef struct {
    logic [7:0]    dev, mod, addr;
    logic [DW-1:0] data;
  } ent_t;

  task automatic test_random();
    ent_t          rq[$];
    ent_t          e;
    int            ph, drops;
    logic [7:0]    m_mod, m_addr;
    logic [DW-1:0] m_data, m_q;
    logic          e_rdy, e_err, acc, loc;
    logic [N_LOC-1:0] e_lv;
    int            sel;
    do_reset();
    ph = 0; drops = 0; m_mod = '0; m_addr = '0; m_data = '0; m_q = '0;
    for (int c = 0; c < 3000; c++) begin
      sel = $urandom_range(0, 3);
      cmd_dev  = (sel == 0) ? DEV_ID : (sel == 1) ? 8'hFF : 8'($urandom_range(2, 254));
      cmd_mod  = 8'($urandom_range(0, 5));
      cmd_addr = 8'($urandom);
      cmd_data = DW'($urandom);
      cmd_vld  = ($urandom_range(0, 1) == 1);
      cmdr_rdy = ($urandom_range(0, 9) < 4);
      cmdl_q   = $urandom;
      #1;
      e_rdy = (ph == 0) && (rq.size() < RF_DEPTH);
      e_lv  = '0;
      if (ph == 1 && int'(m_mod) < N_LOC) e_lv[int'(m_mod)] = 1'b1;
      e_err = (ph == 1) && (int'(m_mod) >= N_LOC);
      n_chk++;
      if ({cmd_rdy, cmdl_vld, cmd_err, cmdr_vld, drop_cnt, cmd_q, cmdl_mod, cmdl_addr, cmdl_data} !==
          {e_rdy, e_lv, e_err, (rq.size() > 0), 8'(drops), m_q, m_mod, m_addr, m_data}) begin
        n_fail++;
        $display("FAIL rand_ctrl c=%0d: got rdy=%b lv=%b err=%b rv=%b drop=%0d q=%h l=%h/%h/%h want %b/%b/%b/%b/%0d/%h/%h/%h/%h",
                 c, cmd_rdy, cmdl_vld, cmd_err, cmdr_vld, drop_cnt, cmd_q, cmdl_mod, cmdl_addr, cmdl_data,
                 e_rdy, e_lv, e_err, (rq.size() > 0), drops, m_q, m_mod, m_addr, m_data);
      end
      if (rq.size() > 0) begin
        n_chk++;
        if ({cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} !== {rq[0].dev, rq[0].mod, rq[0].addr, rq[0].data}) begin
          n_fail++;
          $display("FAIL rand_head c=%0d: got %h/%h/%h/%h want %h/%h/%h/%h", c,
                   cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data, rq[0].dev, rq[0].mod, rq[0].addr, rq[0].data);
        end
      end
      acc = cmd_vld && e_rdy;
      loc = (cmd_dev == DEV_ID) || (cmd_dev == 8'hFF);
      if (cmd_vld && !e_rdy && drops < 255) drops++;
      if (ph == 2) m_q = (int'(m_mod) < N_LOC) ? cmdl_q[int'(m_mod)*DW +: DW] : '1;
      if (ph == 1) ph = 2;
      else if (ph == 2) ph = 0;
      else if (acc && loc) begin
        ph = 1; m_mod = cmd_mod; m_addr = cmd_addr; m_data = cmd_data;
      end
      if (rq.size() > 0 && cmdr_rdy) void'(rq.pop_front());
      if (acc && cmd_dev != DEV_ID) begin
        e.dev = cmd_dev; e.mod = cmd_mod; e.addr = cmd_addr; e.data = cmd_data;
        rq.push_back(e);
      end
      @(posedge clk_sys);
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    cmdl_q = '0;
    test_reset();
    test_local_write();
    test_backpressure();
    test_broadcast();
    test_bad_module();
    test_drop_saturation();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
